// File: rtl/branch_predict_ctrl.sv
// 2-bit saturating-counter direction predictor with EX-stage misprediction flush/redirect.
// Optional resolved/mispredict statistics counters are built when BRANCH_STATS_EN is defined.
module branch_predict_ctrl #(
  parameter int BHT_ENTRIES = 16,
  parameter int INDEX_W     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  input  logic        ex_valid,
  input  logic [2:0]  ex_branch,
  input  logic [31:0] ex_pc,
  input  logic        ex_pred_taken,
  input  logic        ex_actual_taken,
  input  logic [31:0] ex_target,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [31:0] branch_count,
  output logic [31:0] mispredict_count
);

  logic [BHT_ENTRIES-1:0][1:0] bht;
  logic [INDEX_W-1:0]          rd_idx, wr_idx;
  logic                        is_branch, resolved, mispredict;
  logic                        unused_if_pc;

  assign rd_idx       = if_pc[INDEX_W+1:2];
  assign wr_idx       = ex_pc[INDEX_W+1:2];
  assign unused_if_pc = ^{if_pc[31:INDEX_W+2], if_pc[1:0]};

  // No write-to-read bypass: a same-cycle lookup sees the pre-update counter.
  assign pred_taken = bht[rd_idx][1];

  assign is_branch  = (ex_branch != 3'b000) && (ex_branch != 3'b111);
  // EX contents during a flush cycle are wrong-path and must not train or flush.
  assign resolved   = ex_valid && !stall && !flush && is_branch;
  assign mispredict = resolved && (ex_pred_taken != ex_actual_taken);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= 2'b01;
      flush       <= 1'b0;
      redirect_pc <= '0;
    end else begin
      flush <= mispredict;
      if (mispredict)
        redirect_pc <= ex_actual_taken ? ex_target : ex_pc + 32'd4;
      if (resolved) begin
        if (ex_actual_taken && bht[wr_idx] != 2'b11)
          bht[wr_idx] <= bht[wr_idx] + 2'd1;
        else if (!ex_actual_taken && bht[wr_idx] != 2'b00)
          bht[wr_idx] <= bht[wr_idx] - 2'd1;
      end
    end
  end

  assign redirect_valid = flush;

`ifdef BRANCH_STATS_EN
  logic [31:0] br_cnt, mp_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      br_cnt <= '0;
      mp_cnt <= '0;
    end else begin
      if (resolved)   br_cnt <= br_cnt + 32'd1;
      if (mispredict) mp_cnt <= mp_cnt + 32'd1;
    end
  end

  assign branch_count     = br_cnt;
  assign mispredict_count = mp_cnt;
`else
  assign branch_count     = '0;
  assign mispredict_count = '0;
`endif

endmodule

// File: doc/branch_predict_ctrl.md
# branch_predict_ctrl

Direction predictor and misprediction controller for the five-stage pipeline. It holds a table of 2-bit saturating counters indexed by PC and supplies a taken/not-taken prediction to IF. It also checks each EX-stage branch outcome from the branch decision unit against the prediction that travelled with that instruction. On a mismatch it issues a one-cycle registered flush plus a PC redirect, and it trains the table on every resolved branch.

## Interface
- `BHT_ENTRIES`, default 16: counter table depth; must be a power of two, minimum 2.
- `INDEX_W`, default 4: log2(`BHT_ENTRIES`); the table index is `pc[INDEX_W+1:2]`.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `stall` in 1: pipeline stall; EX is held, so EX inputs are ignored this cycle.
- `if_pc` in 32: fetch PC used for lookup.
- `pred_taken` out 1: combinational; MSB of the counter at `if_pc[INDEX_W+1:2]`.
- `ex_valid` in 1: EX holds a live instruction.
- `ex_branch` in 3: branch type (001 eq, 010 ne, 011 lt, 100 gt, 101 le, 110 ge; 000 and 111 mean not a branch).
- `ex_pc` in 32: PC of the EX instruction.
- `ex_pred_taken` in 1: prediction made for this instruction at fetch, piped down.
- `ex_actual_taken` in 1: outcome from the branch decision unit.
- `ex_target` in 32: taken target computed in EX.
- `flush` out 1: registered; kills the IF, ID and EX contents in the cycle it is high.
- `redirect_valid` out 1: registered; equals `flush`.
- `redirect_pc` out 32: registered; the correct next PC.
- `branch_count` out 32: resolved-branch counter (see Configuration).
- `mispredict_count` out 32: misprediction counter (see Configuration).

## Operation
- A branch is resolved in cycle N when all of these hold: `ex_valid`=1, `stall`=0, `flush`=0, and `ex_branch` is in 001..110.
- A misprediction is a resolved branch with `ex_pred_taken` != `ex_actual_taken`.
- On a misprediction in cycle N, cycle N+1 has `flush`=1, `redirect_valid`=1, and `redirect_pc` as follows:
  - `ex_target` if `ex_actual_taken`=1.
  - `ex_pc`+4 if `ex_actual_taken`=0; the add is modulo 2^32, so 0xFFFFFFFC gives 0x00000000.
- In every cycle without a misprediction in the previous cycle, `flush`=0 and `redirect_valid`=0. `redirect_pc` holds its last value.
- A correct prediction produces no flush.
- Counter training on each resolved branch, at index `ex_pc[INDEX_W+1:2]`:
  - Taken: counter increments, saturating at 11.
  - Not taken: counter decrements, saturating at 00.
- Counter encoding: 00 strong not-taken, 01 weak not-taken, 10 weak taken, 11 strong taken.
- Non-branches, stalled cycles and flush cycles update nothing.
- While `flush`=1, the EX inputs belong to a wrong-path instruction and are ignored. Back-to-back flushes are therefore impossible; the minimum spacing is 2 cycles.

## Timing
- Lookup: zero latency. `pred_taken` is combinational from `if_pc` and the current table contents.
- Table write lands at the end of cycle N and is visible to lookups from cycle N+1.
- A lookup in cycle N that hits the index being written in cycle N returns the old value; there is no bypass.
- Misprediction to `flush`/`redirect_valid`: exactly 1 cycle. The pulse lasts exactly 1 cycle.
- `stall`=1 in cycle N: no update, no flush generated. A flush already scheduled for cycle N still asserts and is not extended.
- Reset values:
  - All counters 01.
  - `flush`=0, `redirect_valid`=0, `redirect_pc`=0.
  - Both count outputs 0.
- Reset asserted in the same cycle as a misprediction: reset wins; no flush follows. A pending flush is cleared by reset.

## Configuration
- `BRANCH_STATS_EN` defined:
  - `branch_count` increments on every resolved branch.
  - `mispredict_count` increments on every misprediction.
  - Both are 32-bit, wrap from 0xFFFFFFFF to 0, update in the same edge as table training, and clear on `rst`.
- `BRANCH_STATS_EN` undefined: both outputs are constant 0 and the counter registers are not built. The port list is unchanged.

## Test plan
- Reset, then sweep `if_pc` over 0x00..0x3C -> `pred_taken`=0 for all 16 indices; `flush`=0; `redirect_pc`=0.
- Mispredict not-taken:
  - Stimulus: `ex_branch`=001, `ex_pc`=0x100, `ex_pred_taken`=0, `ex_actual_taken`=1, `ex_target`=0x200.
  - Required: next cycle `flush`=1 and `redirect_pc`=0x200; the cycle after, `flush`=0; lookup of 0x100 now gives `pred_taken`=1 (counter 10).
- Saturation: four taken resolutions at `ex_pc`=0x8, then one not-taken with `ex_pred_taken`=1 -> counter goes 11 then 10; `pred_taken` stays 1; that one not-taken resolution flushes with `redirect_pc`=0xC.
- Ignore cases, each with a mismatched prediction:
  - `stall`=1 -> no flush, no counter change.
  - `ex_branch`=000 -> no flush, no counter change.
  - `ex_branch`=111 -> no flush, no counter change.
  - Misprediction presented during a flush cycle -> no second flush.
- Wrap: not-taken mispredict at `ex_pc`=0xFFFFFFFC -> `redirect_pc`=0x00000000.
- With `BRANCH_STATS_EN`: 3 correct plus 2 mispredicted branches, then `rst` -> counts 5/2 before reset, 0/0 after. Without the macro, both outputs stay 0 throughout.
